traditional_divider16: RTL and testbench



---
 rtl/traditional_divider_pkg.sv | 10 +
 rtl/traditional_divider16_step.sv | 19 +
 rtl/traditional_divider16.sv | 113 +++++++++++
 tb/tb_traditional_divider16.sv | 120 ++++++++++++
 4 files changed

// File: rtl/traditional_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package traditional_divider_pkg;
   localparam int DEF_WIDTH = 8;
   localparam int CNT_W     = $clog2(DEF_WIDTH);

   typedef enum logic {
      IDLE = 1'b0,
      CALC = 1'b1
   } div_state_e;
endpackage

// File: rtl/traditional_divider16_step.sv
// One combinational restoring-division stage: shift in a dividend bit, trial-subtract.
module divider_step #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] rem,
   input  logic             dividend_bit,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] next_rem,
   output logic             q_bit
);
   logic [WIDTH:0]   shifted;
   logic [WIDTH+1:0] trial;

   assign shifted = {rem, dividend_bit};
   // Extra top bit of the difference is the borrow: set means trial went negative.
   assign trial    = {1'b0, shifted} - {2'b00, divisor};
   assign q_bit    = ~trial[WIDTH+1];
   assign next_rem = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
endmodule

// File: rtl/traditional_divider16.sv
// 2W-by-W unsigned restoring divider, one quotient bit per clock.
// Optional macro DIVIDER_ERR_FLAGS_EN adds zero-divisor/overflow detection with a 1-cycle fast path.
module traditional_divider16
   import traditional_divider_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               start_i,
   input  logic [2*WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0]   divisor_i,
   output logic               ready_o,
   output logic               valid_o,
   output logic [WIDTH-1:0]   quotient_o,
   output logic [WIDTH-1:0]   remainder_o,
   output logic               div_by_zero_o,
   output logic               overflow_o
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   div_state_e       state_q, state_d;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] rem_q, lo_q, dvs_q, err_rem_q;
   logic             err_pend_q, dz_q, ov_q;
   logic             accept, dz_req, ov_req, err_req;
   logic [WIDTH-1:0] step_rem;
   logic             step_q;

`ifdef DIVIDER_ERR_FLAGS_EN
   assign dz_req = (divisor_i == '0);
   assign ov_req = ~dz_req && (dividend_i[2*WIDTH-1:WIDTH] >= divisor_i);
`else
   assign dz_req = 1'b0;
   assign ov_req = 1'b0;
`endif
   assign err_req = dz_req | ov_req;

   // A pending fast-path result holds off new requests for its one cycle.
   assign ready_o       = (state_q == IDLE) && !err_pend_q;
   assign accept        = start_i && ready_o;
   assign div_by_zero_o = dz_q;
   assign overflow_o    = ov_q;

   divider_step #(.WIDTH(WIDTH)) u_step (
      .rem          (rem_q),
      .dividend_bit (lo_q[WIDTH-1]),
      .divisor      (dvs_q),
      .next_rem     (step_rem),
      .q_bit        (step_q)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (accept && !err_req) state_d = CALC;
         CALC: if (cnt_q == '0)        state_d = IDLE;
         default:                      state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q       <= '0;
         rem_q       <= '0;
         lo_q        <= '0;
         dvs_q       <= '0;
         err_rem_q   <= '0;
         err_pend_q  <= 1'b0;
         dz_q        <= 1'b0;
         ov_q        <= 1'b0;
         valid_o     <= 1'b0;
         quotient_o  <= '0;
         remainder_o <= '0;
      end else begin
         valid_o <= 1'b0;
         if (err_pend_q) begin
            err_pend_q  <= 1'b0;
            valid_o     <= 1'b1;
            quotient_o  <= '1;
            remainder_o <= err_rem_q;
         end else if (accept) begin
            dz_q <= dz_req;
            ov_q <= ov_req;
            if (err_req) begin
               err_pend_q <= 1'b1;
               err_rem_q  <= dz_req ? dividend_i[WIDTH-1:0] : '0;
            end else begin
               cnt_q <= CW'(WIDTH - 1);
               rem_q <= dividend_i[2*WIDTH-1:WIDTH];
               lo_q  <= dividend_i[WIDTH-1:0];
               dvs_q <= divisor_i;
            end
         end else if (state_q == CALC) begin
            // Dividend bits leave the top of lo_q as quotient bits enter the bottom.
            rem_q <= step_rem;
            lo_q  <= {lo_q[WIDTH-2:0], step_q};
            if (cnt_q == '0) begin
               valid_o     <= 1'b1;
               quotient_o  <= {lo_q[WIDTH-2:0], step_q};
               remainder_o <= step_rem;
            end else begin
               cnt_q <= cnt_q - 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_traditional_divider16.sv
// Directed self-checking bench for traditional_divider16 (W=8).
module tb_traditional_divider16;
   logic        clk = 1'b0;
   logic        rst, start;
   logic [15:0] dividend;
   logic [7:0]  divisor;
   logic        ready, valid, dz, ov;
   logic [7:0]  quotient, remainder;
   int          vectors = 0;
   int          miscompares = 0;
   int          lat, vcount;

   traditional_divider16 #(.WIDTH(8)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start),
      .dividend_i(dividend), .divisor_i(divisor),
      .ready_o(ready), .valid_o(valid),
      .quotient_o(quotient), .remainder_o(remainder),
      .div_by_zero_o(dz), .overflow_o(ov)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [15:0] dd, input logic [7:0] dv);
      @(negedge clk);
      dividend = dd; divisor = dv; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Edges counted after the acceptance edge until valid is seen; returns at the negedge.
   task automatic wait_valid(output int edges);
      edges = 0;
      do begin
         @(posedge clk);
         edges++;
         @(negedge clk);
      end while (!valid && edges < 30);
   endtask

   task automatic result(input string tag, input int exp_lat, input logic [7:0] q, input logic [7:0] r,
                         input logic edz, input logic eov);
      wait_valid(lat);
      chk({tag, " latency"}, lat, exp_lat);
      chk({tag, " quotient"}, quotient, q);
      chk({tag, " remainder"}, remainder, r);
      chk({tag, " div_by_zero"}, dz, edz);
      chk({tag, " overflow"}, ov, eov);
      chk({tag, " ready with valid"}, ready, 1'b1);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset ready", ready, 1'b1);
      chk("reset valid", valid, 1'b0);
      chk("reset outputs", {quotient, remainder, dz, ov}, 18'h0);
      rst = 1'b0;

      issue(16'h138A, 8'h7A);
      result("138A/7A", 8, 8'h29, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      chk("valid one cycle wide", valid, 1'b0);

      issue(16'h1234, 8'h56);
      result("1234/56", 8, 8'h36, 8'h10, 1'b0, 1'b0);
      // start held in the valid cycle: accepted back-to-back
      dividend = 16'hFE01; divisor = 8'hFF; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      result("FE01/FF b2b", 8, 8'hFF, 8'h00, 1'b0, 1'b0);

`ifdef DIVIDER_ERR_FLAGS_EN
      issue(16'h00AB, 8'h00);
      result("00AB/00", 1, 8'hFF, 8'hAB, 1'b1, 1'b0);
      issue(16'h8000, 8'h80);
      result("8000/80", 1, 8'hFF, 8'h00, 1'b0, 1'b1);
`endif

      issue(16'h00FF, 8'h10);
      result("00FF/10", 8, 8'h0F, 8'h0F, 1'b0, 1'b0);

      // Abort: ignored start at step 3, reset at step 5.
      issue(16'h1234, 8'h56);
      vcount = 0;
      @(posedge clk); @(negedge clk); vcount += int'(valid);
      @(posedge clk); @(negedge clk); vcount += int'(valid);
      dividend = 16'h0001; divisor = 8'h01; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk); vcount += int'(valid);
      chk("busy ignores start", ready, 1'b0);
      @(posedge clk); @(negedge clk); vcount += int'(valid);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("abort ready", ready, 1'b1);
      chk("abort valid", valid, 1'b0);
      chk("abort outputs", {quotient, remainder, dz, ov}, 18'h0);
      repeat (12) begin
         @(negedge clk); vcount += int'(valid);
      end
      chk("no valid after abort", vcount, 0);

      issue(16'h0011, 8'h20);
      result("0011/20", 8, 8'h00, 8'h11, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
